comb_gates_nway_pipe: RTL and testbench

// Parametrised, pipelined N-input reduction gate unit: the wide successor to
// the 4-input AND/NAND/OR/NOR block. Reduces a p_nbits vector to AND, NAND,
// OR, NOR, XOR, XNOR and a ones-count.
// Two register stages with valid/ready on both sides, so it sits directly in

---
 rtl/comb_gates_nway_pipe.sv | 129 ++++++++++++
 tb/tb_comb_gates_nway_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_gates_nway_pipe.sv
// rtl/comb_gates_nway_pipe.sv - two-stage pipelined N-input AND/NAND/OR/NOR/XOR/XNOR/popcount reducer
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         asynchronous, active-high; empties the pipe and clears data
//   in_val        input transaction valid
//   in_rdy        block can accept an input this cycle
//   in            p_nbits-wide vector to reduce
//   out_val       result valid
//   out_rdy       downstream accepts the result
//   out_and       &in          out_nand   ~&in
//   out_or        |in          out_nor    ~|in
//   out_xor       ^in          out_xnor   ~^in
//   out_popcount  number of 1 bits in in
`timescale 1ns/1ps

module comb_gates_nway_pipe #(
  parameter int p_nbits = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_val,
  output logic                         in_rdy,
  input  logic [p_nbits-1:0]           in,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic                         out_and,
  output logic                         out_nand,
  output logic                         out_or,
  output logic                         out_nor,
  output logic                         out_xor,
  output logic                         out_xnor,
  output logic [$clog2(p_nbits+1)-1:0] out_popcount
);

  localparam int p_ngroups = p_nbits / 4;
  localparam int p_cw      = $clog2(p_nbits + 1);

  // Per-group reductions of the incoming vector (stage-1 inputs)
  logic [p_ngroups-1:0]      g_and;
  logic [p_ngroups-1:0]      g_or;
  logic [p_ngroups-1:0]      g_xor;
  logic [p_ngroups-1:0][2:0] g_cnt;

  // Stage 1 registers
  logic                      s1_val;
  logic [p_ngroups-1:0]      s1_and;
  logic [p_ngroups-1:0]      s1_or;
  logic [p_ngroups-1:0]      s1_xor;
  logic [p_ngroups-1:0][2:0] s1_cnt;

  // Stage 2 registers
  logic                      s2_val;
  logic                      s2_and;
  logic                      s2_or;
  logic                      s2_xor;
  logic [p_cw-1:0]           s2_cnt;

  logic                      s1_load;
  logic                      s2_load;
  logic [p_cw-1:0]           cnt_sum;

  // A stage may load when it is empty or when its contents move on this edge.
  // in_rdy therefore depends on out_rdy and the valid flags, never on in_val.
  assign s2_load = !s2_val || out_rdy;
  assign s1_load = !s1_val || s2_load;
  assign in_rdy  = s1_load;

  always_comb begin
    g_and = '0;
    g_or  = '0;
    g_xor = '0;
    g_cnt = '0;
    for (int g = 0; g < p_ngroups; g++) begin
      g_and[g] = &in[4*g +: 4];
      g_or[g]  = |in[4*g +: 4];
      g_xor[g] = ^in[4*g +: 4];
      g_cnt[g] = 3'(in[4*g]) + 3'(in[4*g+1]) + 3'(in[4*g+2]) + 3'(in[4*g+3]);
    end
  end

  // Sum of group counts; the popcount width always holds p_nbits, so no overflow
  always_comb begin
    cnt_sum = '0;
    for (int g = 0; g < p_ngroups; g++) begin
      cnt_sum = cnt_sum + p_cw'(s1_cnt[g]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_val <= 1'b0;
      s1_and <= '0;
      s1_or  <= '0;
      s1_xor <= '0;
      s1_cnt <= '0;
      s2_val <= 1'b0;
      s2_and <= 1'b0;
      s2_or  <= 1'b0;
      s2_xor <= 1'b0;
      s2_cnt <= '0;
    end else begin
      if (s1_load) begin
        s1_val <= in_val;
        s1_and <= g_and;
        s1_or  <= g_or;
        s1_xor <= g_xor;
        s1_cnt <= g_cnt;
      end
      if (s2_load) begin
        s2_val <= s1_val;
        s2_and <= &s1_and;
        s2_or  <= |s1_or;
        s2_xor <= ^s1_xor;
        s2_cnt <= cnt_sum;
      end
    end
  end

  assign out_val      = s2_val;
  assign out_and      = s2_and;
  assign out_nand     = ~s2_and;
  assign out_or       = s2_or;
  assign out_nor      = ~s2_or;
  assign out_xor      = s2_xor;
  assign out_xnor     = ~s2_xor;
  assign out_popcount = s2_cnt;

endmodule

// File: tb/tb_comb_gates_nway_pipe.sv
// tb/tb_comb_gates_nway_pipe.sv - self-checking bench for comb_gates_nway_pipe (16, 4 and 64 bit widths)
`timescale 1ns/1ps

module tb_comb_gates_nway_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [15:0] din;
  logic        out_val;
  logic        out_rdy;
  logic        o_and, o_nand, o_or, o_nor, o_xor, o_xnor;
  logic [4:0]  o_pop;

  logic        v4_in_val, v4_in_rdy, v4_out_val;
  logic [3:0]  v4_in;
  logic        v4_and, v4_nand, v4_or, v4_nor, v4_xor, v4_xnor;
  logic [2:0]  v4_pop;

  logic        v64_in_val, v64_in_rdy, v64_out_val;
  logic [63:0] v64_in;
  logic        v64_and, v64_nand, v64_or, v64_nor, v64_xor, v64_xnor;
  logic [6:0]  v64_pop;

  int checks   = 0;
  int failures = 0;
  int n_results = 0;

  logic [15:0] exp_q[$];
  logic [15:0] stream_vec[8];

  bit          stall = 0;
  logic [4:0]  h_pop;
  logic [5:0]  h_flags;

  always #5 clk = ~clk;

  comb_gates_nway_pipe #(.p_nbits(16)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in(din),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_and(o_and), .out_nand(o_nand), .out_or(o_or), .out_nor(o_nor),
    .out_xor(o_xor), .out_xnor(o_xnor), .out_popcount(o_pop)
  );

  comb_gates_nway_pipe #(.p_nbits(4)) dut4 (
    .clk(clk), .reset(reset), .in_val(v4_in_val), .in_rdy(v4_in_rdy), .in(v4_in),
    .out_val(v4_out_val), .out_rdy(1'b1),
    .out_and(v4_and), .out_nand(v4_nand), .out_or(v4_or), .out_nor(v4_nor),
    .out_xor(v4_xor), .out_xnor(v4_xnor), .out_popcount(v4_pop)
  );

  comb_gates_nway_pipe #(.p_nbits(64)) dut64 (
    .clk(clk), .reset(reset), .in_val(v64_in_val), .in_rdy(v64_in_rdy), .in(v64_in),
    .out_val(v64_out_val), .out_rdy(1'b1),
    .out_and(v64_and), .out_nand(v64_nand), .out_or(v64_or), .out_nor(v64_nor),
    .out_xor(v64_xor), .out_xnor(v64_xnor), .out_popcount(v64_pop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] golden_flags(input logic [15:0] v);
    return {&v, ~&v, |v, ~|v, ^v, ~^v};
  endfunction

  // Scoreboard: every negedge, outputs are compared to the oldest accepted input.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      stall <= 0;
    end else begin
      if (stall) begin
        chk("hold_pop", 64'(o_pop), 64'(h_pop));
        chk("hold_flags", 64'({o_and, o_nand, o_or, o_nor, o_xor, o_xnor}), 64'(h_flags));
      end
      if (out_val) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(out_val), 64'd0);
        end else begin
          chk("res_pop", 64'(o_pop), 64'($countones(exp_q[0])));
          chk("res_flags", 64'({o_and, o_nand, o_or, o_nor, o_xor, o_xnor}),
              64'(golden_flags(exp_q[0])));
          if (out_rdy) begin
            void'(exp_q.pop_front());
            n_results++;
          end
        end
      end
      stall   <= out_val && !out_rdy;
      h_pop   <= o_pop;
      h_flags <= {o_and, o_nand, o_or, o_nor, o_xor, o_xnor};
      if (in_val && in_rdy) exp_q.push_back(din);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [15:0] v);
    in_val = 1'b1;
    din    = v;
    tick();
    in_val = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    in_val     = 1'b0;
    din        = '0;
    out_rdy    = 1'b1;
    v4_in_val  = 1'b0;
    v4_in      = '0;
    v64_in_val = 1'b0;
    v64_in     = '0;
    #1;
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_flags", 64'({o_and, o_nand, o_or, o_nor, o_xor, o_xnor}), 64'b010101);
    chk("rst_pop", 64'(o_pop), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Basic all-ones, two-cycle latency
    send1(16'hFFFF);
    @(negedge clk);
    chk("basic_not_yet", 64'(out_val), 64'd0);
    tick();
    chk("basic_val", 64'(out_val), 64'd1);
    chk("basic_flags", 64'({o_and, o_nand, o_or, o_nor, o_xor, o_xnor}), 64'b101001);
    chk("basic_pop", 64'(o_pop), 64'd16);
    repeat (2) tick();

    // Zero then single bit, back-to-back
    in_val = 1'b1;
    din    = 16'h0000;
    tick();
    din    = 16'h0100;
    tick();
    in_val = 1'b0;
    chk("zero_flags", 64'({o_and, o_nand, o_or, o_nor, o_xor, o_xnor}), 64'b010101);
    chk("zero_pop", 64'(o_pop), 64'd0);
    tick();
    chk("single_val", 64'(out_val), 64'd1);
    chk("single_flags", 64'({o_and, o_nand, o_or, o_nor, o_xor, o_xnor}), 64'b011010);
    chk("single_pop", 64'(o_pop), 64'd1);
    repeat (2) tick();

    // Streaming: 8 vectors back-to-back, one result per cycle
    for (int k = 0; k < 8; k++) stream_vec[k] = 16'($urandom);
    for (int k = 0; k < 8; k++) begin
      in_val = 1'b1;
      din    = stream_vec[k];
      tick();
    end
    in_val = 1'b0;
    @(negedge clk);
    chk("stream_val6", 64'(out_val), 64'd1);
    chk("stream_pop6", 64'(o_pop), 64'($countones(stream_vec[6])));
    tick();
    chk("stream_val7", 64'(out_val), 64'd1);
    chk("stream_pop7", 64'(o_pop), 64'($countones(stream_vec[7])));
    tick();
    chk("stream_done", 64'(out_val), 64'd0);
    tick();

    // Backpressure: two accepted, third stalls with in_rdy low
    out_rdy = 1'b0;
    in_val  = 1'b1;
    din     = 16'h00F3;
    tick();
    din     = 16'h1234;
    tick();
    din     = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_rdy", 64'(in_rdy), 64'd0);
      chk("bp_out_val", 64'(out_val), 64'd1);
      chk("bp_pop_head", 64'(o_pop), 64'd6);
      tick();
    end
    out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", 64'(in_rdy), 64'd1);
    tick();
    in_val = 1'b0;
    repeat (4) tick();

    // Reset mid-stream with both stages full
    out_rdy = 1'b0;
    in_val  = 1'b1;
    din     = 16'hAAAA;
    tick();
    din     = 16'h5555;
    tick();
    in_val  = 1'b0;
    chk("pre_rst_full", 64'({out_val, in_rdy}), 64'b10);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_val", 64'(out_val), 64'd0);
    chk("mid_rst_pop", 64'(o_pop), 64'd0);
    chk("mid_rst_nand", 64'(o_nand), 64'd1);
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
    tick();
    reset   = 1'b0;
    out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(out_val), 64'd0);
    end
    tick();

    // Width sweep on the 4- and 64-bit instances
    v4_in_val = 1'b1;
    v4_in     = 4'hF;
    v64_in_val = 1'b1;
    v64_in    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    v64_in    = 64'h8000_0000_0000_0001;
    v4_in_val = 1'b0;
    tick();
    v64_in_val = 1'b0;
    chk("w4_val", 64'(v4_out_val), 64'd1);
    chk("w4_pop", 64'(v4_pop), 64'd4);
    chk("w4_and_xor", 64'({v4_and, v4_xor}), 64'b10);
    chk("w64_ones_pop", 64'(v64_pop), 64'd64);
    chk("w64_ones_and_xor", 64'({v64_and, v64_xor}), 64'b10);
    tick();
    chk("w64_ends_val", 64'(v64_out_val), 64'd1);
    chk("w64_ends_pop", 64'(v64_pop), 64'd2);
    chk("w64_ends_and_xor", 64'({v64_and, v64_xor}), 64'b00);
    tick();

    chk("all_drained", 64'(exp_q.size()), 64'd0);
    chk("result_count", 64'(n_results), 64'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
